// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one spi_master among NREQ requesters.
// Define SPI_ARB_TIMEOUT_EN to abort a transfer after TO_CYC cycles without TXC.
module spi_xfer_arbiter #(
  parameter int data    = 8,
  parameter int address = 3,
  parameter int NREQ    = 2,
  parameter int TO_CYC  = 255
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_wr,
  input  logic [NREQ*address-1:0]   req_addr,
  input  logic [NREQ*data-1:0]      req_wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [data-1:0]           rdata,
  output logic                      err,
  output logic                      busy,
  output logic                      spe,
  output logic                      m_wr_rdbar,
  output logic [address-1:0]        m_addr,
  output logic [data-1:0]           m_wdata,
  input  logic [data-1:0]           m_rdata,
  input  logic                      TXC
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;
  state_t          r_state;
  logic [IW-1:0]   r_rr, r_win, w_win;
  logic [NREQ-1:0] w_rot;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1) > 8 ? $clog2(TO_CYC + 1) : 8;
  logic [CW-1:0] r_cnt;
`else
  assign err = TO_CYC < 0;
`endif
  assign busy = r_state != IDLE;
  // rotate so bit 0 is the rr pointer; lowest set bit is the winner's offset
  always_comb begin
    w_rot = NREQ'({req, req} >> r_rr);
    w_win = r_rr;
    for (int k = NREQ - 1; k >= 0; k--)
      if (w_rot[k]) w_win = IW'(int'(r_rr) + k >= NREQ ? int'(r_rr) + k - NREQ : int'(r_rr) + k);
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state    <= IDLE;
      r_rr       <= '0;
      r_win      <= '0;
      gnt        <= '0;
      done       <= '0;
      rdata      <= '0;
      spe        <= 1'b0;
      m_wr_rdbar <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err        <= 1'b0;
      r_cnt      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (|req) begin
          r_win   <= w_win;
          gnt     <= NREQ'(1) << w_win;
          r_rr    <= w_win == IW'(NREQ - 1) ? '0 : w_win + 1'b1;
          r_state <= GRANT;
        end
        GRANT: begin
          m_wr_rdbar <= req_wr[r_win];
          m_addr     <= req_addr[r_win*address +: address];
          m_wdata    <= req_wdata[r_win*data +: data];
          spe        <= 1'b1;
          r_state    <= XFER;
`ifdef SPI_ARB_TIMEOUT_EN
          err        <= 1'b0;
          r_cnt      <= '0;
`endif
        end
        XFER: begin
          if (TXC) begin
            rdata   <= m_rdata;
            spe     <= 1'b0;
            done    <= gnt;
            r_state <= DONE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (r_cnt == CW'(TO_CYC - 1)) begin
            rdata   <= '0;
            err     <= 1'b1;
            spe     <= 1'b0;
            done    <= gnt;
            r_state <= DONE;
          end else r_cnt <= r_cnt + 1'b1;
`endif
        end
        default: begin
          done    <= '0;
          gnt     <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: scoreboard bench for spi_xfer_arbiter (SPI_ARB_TIMEOUT_EN selects timeout case).
module tb_spi_xfer_arbiter;
  logic       clk = 1'b0, rst_n;
  logic [1:0] req, req_wr, gnt, done;
  logic [5:0] req_addr;
  logic [15:0] req_wdata;
  logic [7:0] rdata, m_wdata, m_rdata;
  logic       err, busy, spe, m_wr_rdbar, txc;
  logic [2:0] m_addr;
  logic [10:0] sb[$];
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  spi_xfer_arbiter #(.data(8), .address(3), .NREQ(2), .TO_CYC(20)) dut (
    .PCLK(clk), .PRESETn(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err), .busy(busy),
    .spe(spe), .m_wr_rdbar(m_wr_rdbar), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .TXC(txc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every done pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done !== 2'b00) begin
      if (sb.size() == 0) check("unexpected_done", {done, rdata, err}, 11'h0);
      else check("done_rdata_err", {done, rdata, err}, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [1:0] eg, input logic [2:0] ea, input logic [7:0] ew,
                       input logic ewr, input logic [7:0] rd, input int lat);
    int n = 0;
    while (gnt == 2'b00 && n < 10) begin tick(); n++; end
    check("gnt", gnt, eg);
    check("gnt_lat", n, 1);
    check("busy", busy, 1);
    n = 0;
    while (!spe && n < 10) begin tick(); n++; end
    check("spe_lat", n, 1);
    check("m_addr", m_addr, ea);
    check("m_wdata", m_wdata, ew);
    check("m_wr_rdbar", m_wr_rdbar, ewr);
    req_addr = ~req_addr;
    req_wdata = ~req_wdata;
    repeat (lat) tick();
    check("m_addr_hold", m_addr, ea);
    check("m_wdata_hold", m_wdata, ew);
    check("spe_hold", spe, 1);
    req_addr = ~req_addr;
    req_wdata = ~req_wdata;
    sb.push_back({eg, rd, 1'b0});
    m_rdata = rd;
    txc = 1'b1;
    tick();
    txc = 1'b0;
    check("done_lat", done, eg);
    check("spe_off", spe, 0);
    tick();
    check("busy_idle", busy, 0);
    check("gnt_clr", gnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b11; req_wr = 2'b00; req_addr = '0; req_wdata = '0;
    m_rdata = 8'h00; txc = 1'b0;
    // reset holds everything quiet even with both requests up
    repeat (2) begin
      tick();
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_spe", spe, 0);
      check("rst_busy", busy, 0);
    end
    req = 2'b00;
    rst_n = 1'b1;
    tick();
    // TXC while idle must be ignored
    txc = 1'b1;
    tick();
    txc = 1'b0;
    check("txc_idle_busy", busy, 0);
    tick();
    // single write from requester 0
    req_wr = 2'b01; req_addr = {3'd4, 3'd1}; req_wdata = {8'h77, 8'hA5};
    req = 2'b01;
    serve(2'b01, 3'd1, 8'hA5, 1'b1, 8'h5A, 3);
    req = 2'b00;
    // read from requester 1, rdata held afterwards
    req_wr = 2'b00; req_addr = {3'd6, 3'd2};
    tick();
    req = 2'b10;
    serve(2'b10, 3'd6, 8'h77, 1'b0, 8'h3C, 2);
    req = 2'b00;
    repeat (3) tick();
    check("rdata_held", rdata, 8'h3C);
    // fairness with both requests held
    req_wr = 2'b01; req_addr = {3'd5, 3'd2}; req_wdata = {8'h22, 8'h11};
    req = 2'b11;
    serve(2'b01, 3'd2, 8'h11, 1'b1, 8'hC1, 8);
    serve(2'b10, 3'd5, 8'h22, 1'b0, 8'hC2, 8);
    serve(2'b01, 3'd2, 8'h11, 1'b1, 8'hC3, 8);
    serve(2'b10, 3'd5, 8'h22, 1'b0, 8'hC4, 8);
    // reset mid-transfer after granting requester 0 (rr would point at 1)
    tick();
    check("pre_rst_gnt", gnt, 2'b01);
    tick();
    check("pre_rst_spe", spe, 1);
    rst_n = 1'b0;
    tick();
    check("midrst_spe", spe, 0);
    check("midrst_gnt", gnt, 0);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("rr_reset_gnt", gnt, 2'b01);
    req = 2'b00;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`ifdef SPI_ARB_TIMEOUT_EN
    begin
      int n = 0;
      req = 2'b01; m_rdata = 8'hEE;
      while (!spe && n < 10) begin tick(); n++; end
      check("to_spe", spe, 1);
      sb.push_back({2'b01, 8'h00, 1'b1});
      n = 0;
      while (done == 2'b00 && n < 100) begin tick(); n++; end
      check("to_cycles", n, 20);
      check("to_err", err, 1);
      req = 2'b00;
      repeat (2) tick();
    end
`else
    begin
      int n = 0, bad = 0;
      req = 2'b01;
      while (!spe && n < 10) begin tick(); n++; end
      check("hang_spe", spe, 1);
      repeat (300) begin
        tick();
        if (!spe || err || done != 2'b00) bad++;
      end
      check("hang_steady", bad, 0);
      req = 2'b00;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
    end
`endif
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
